// File: rtl/clock_period_meter.sv
`default_nettype none
// ============================================================================
// Module      : clock_period_meter
// Description : Measures period and high time of a slow asynchronous square
//               wave in clock_in cycles, with valid/ready result hand-off.
// Revision    : 1.0 - initial release
// ============================================================================
module clock_period_meter #(
    parameter int CNT_W          = 23,
    parameter int TIMEOUT_CYCLES = 8388607
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             sig_in,
    input  logic             meas_ready,
    output logic             meas_valid,
    output logic [CNT_W-1:0] period_out,
    output logic [CNT_W-1:0] high_out,
    output logic             edge_pulse,
    output logic             timeout,
    output logic             overrun
);

    typedef enum logic [0:0] {
        ARM     = 1'b0,
        MEASURE = 1'b1
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

    logic             sync1;
    logic             sync2;
    logic             prev;
    logic             rise;
    logic             rise_q;
    logic             accept;
    logic             complete;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] period_cnt;
    logic [CNT_W-1:0] period_cnt_nxt;
    logic [CNT_W-1:0] high_cnt;
    logic [CNT_W-1:0] high_cnt_nxt;
    logic [CNT_W-1:0] period_nxt;
    logic [CNT_W-1:0] high_nxt;
    logic             valid_nxt;
    logic             timeout_nxt;
    logic             overrun_nxt;

    assign rise   = sync2 & ~prev;
    assign accept = meas_valid & meas_ready;

    // edge_pulse trails rise by one extra stage: it asserts on the fourth
    // edge counting the one that first samples sig_in high.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            sync1      <= 1'b0;
            sync2      <= 1'b0;
            prev       <= 1'b0;
            rise_q     <= 1'b0;
            edge_pulse <= 1'b0;
        end else begin
            sync1      <= sig_in;
            sync2      <= sync1;
            prev       <= sync2;
            rise_q     <= rise;
            edge_pulse <= rise_q;
        end
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ARM;
            period_cnt <= '0;
            high_cnt   <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            state      <= state_nxt;
            period_cnt <= period_cnt_nxt;
            high_cnt   <= high_cnt_nxt;
            period_out <= period_nxt;
            high_out   <= high_nxt;
            meas_valid <= valid_nxt;
            timeout    <= timeout_nxt;
            overrun    <= overrun_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        period_cnt_nxt = period_cnt;
        high_cnt_nxt   = high_cnt;
        period_nxt     = period_out;
        high_nxt       = high_out;
        valid_nxt      = meas_valid;
        timeout_nxt    = timeout;
        overrun_nxt    = overrun;
        complete       = 1'b0;

        case (state)
            ARM: begin
                period_cnt_nxt = '0;
                high_cnt_nxt   = '0;
                if (rise) begin
                    state_nxt      = MEASURE;
                    period_cnt_nxt = CNT_ONE;
                    high_cnt_nxt   = CNT_ONE;
                    timeout_nxt    = 1'b0;
                end
            end
            MEASURE: begin
                if (rise) begin
                    complete       = 1'b1;
                    period_cnt_nxt = CNT_ONE;
                    high_cnt_nxt   = CNT_ONE;
                    timeout_nxt    = 1'b0;
                end else if (period_cnt == CNT_LIMIT) begin
                    state_nxt      = ARM;
                    period_cnt_nxt = '0;
                    high_cnt_nxt   = '0;
                    timeout_nxt    = 1'b1;
                end else begin
                    period_cnt_nxt = period_cnt + CNT_ONE;
                    if (sync2) begin
                        high_cnt_nxt = high_cnt + CNT_ONE;
                    end
                end
            end
            default: state_nxt = ARM;
        endcase

        // A dropped result needs meas_ready low, so it never coincides with an accept.
        if (complete && meas_valid && !meas_ready) begin
            overrun_nxt = 1'b1;
        end else begin
            if (accept) begin
                overrun_nxt = 1'b0;
            end
            if (complete) begin
                period_nxt = period_cnt;
                high_nxt   = high_cnt;
                valid_nxt  = 1'b1;
            end else if (accept) begin
                valid_nxt = 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
